sha256_msg_schedule: RTL

SHA-256 message-schedule generator for the miner's hashing core. It accepts one 512-bit padded message block and streams the 64 expanded schedule words W[0]..W[63], one per clock. The 64-step round counter and the compression-round datapath downstream consume the stream. Word 0 appears in the cycle the round counter leaves its restart value, and the counter and this block then advance in lockstep with no stall.

---
 rtl/sha256_pkg.sv | 25 ++
 rtl/sha256_sched_next.sv | 33 +++
 rtl/sha256_msg_schedule.sv | 76 +++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared constants, word type and small-sigma helpers.
// Combinational only; no latency or backpressure of its own.
// Imported by both the message schedule and the compression stage.
package sha256_pkg;

    localparam int NUM_ROUNDS = 64;
    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 512;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    function automatic word_t sigma0_small(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t sigma1_small(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_sched_next.sv
// Next schedule word: sigma1(w14) + w9 + sigma0(w1) + w0, mod 2^32.
// Purely combinational, zero latency; no backpressure.
// Two carry-save stages reduce four operands to two before one carry-propagate add.
module sha256_sched_next
    import sha256_pkg::*;
(
    input  word_t w0,
    input  word_t w1,
    input  word_t w9,
    input  word_t w14,
    output word_t next_w
);

    word_t op_a, op_b, op_c, op_d;
    word_t s1, c1, s2, c2;

    always_comb begin
        op_a = sigma1_small(w14);
        op_b = w9;
        op_c = sigma0_small(w1);
        op_d = w0;

        // Carry vectors are shifted left; the bit leaving the MSB is the discarded mod-2^32 carry.
        s1 = op_a ^ op_b ^ op_c;
        c1 = ((op_a & op_b) | (op_a & op_c) | (op_b & op_c)) << 1;

        s2 = s1 ^ c1 ^ op_d;
        c2 = ((s1 & c1) | (s1 & op_d) | (c1 & op_d)) << 1;

        next_w = s2 + c2;
    end

endmodule

// File: rtl/sha256_msg_schedule.sv
// Streams W[0..63] for one 512-bit block, one word per clock from a 16-word sliding window.
// Latency: W[0] in the cycle after the accepting edge; W[63] and done 63 cycles later.
// Backpressure: ready only in IDLE or on W[63]; the stream itself never stalls.
module sha256_msg_schedule #(
    parameter int NUM_ROUNDS = 64,
    parameter int IDX_BITS   = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [sha256_pkg::BLOCK_W-1:0] block_in,
    output logic                           ready,
    output logic                           w_valid,
    output logic [31:0]                    w_out,
    output logic [IDX_BITS-1:0]            w_index,
    output logic                           done
);

    import sha256_pkg::*;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_ROUNDS - 1);

    sched_state_t state_q, state_d;
    word_t        win [16];
    word_t        next_w;
    logic         at_last;
    logic         accept;

    sha256_sched_next u_next (
        .w0     (win[0]),
        .w1     (win[1]),
        .w9     (win[9]),
        .w14    (win[14]),
        .next_w (next_w)
    );

    assign at_last = (w_index == LAST_IDX);
    assign ready   = (state_q == ST_IDLE) || at_last;
    assign w_valid = (state_q == ST_RUN);
    assign done    = (state_q == ST_RUN) && at_last;
    assign accept  = load && ready;
    assign w_out   = win[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load) state_d = ST_RUN;
            ST_RUN:  if (at_last) state_d = load ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // After W[63] without a new block the window freezes, so w_out/w_index hold in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_index <= '0;
            for (int k = 0; k < 16; k++) win[k] <= '0;
        end else if (accept) begin
            w_index <= '0;
            for (int k = 0; k < 16; k++) win[k] <= block_in[BLOCK_W-1-WORD_W*k -: WORD_W];
        end else if (state_q == ST_RUN && !at_last) begin
            w_index <= w_index + 1'b1;
            for (int k = 0; k < 15; k++) win[k] <= win[k+1];
            win[15] <= next_w;
        end
    end

endmodule
